wordle_game_ctrl: RTL and testbench

Central sequencer for the Wordle game. It walks the player through three phases: setup (enter the guess limit and the secret digits), guessing (enter the guess digits), and a sequential per-position compare. It also tracks the remaining attempts and declares win or lose. It sits between the switch front end and the seven-segment/LED drivers, and publishes the secret, the current guess and the compare masks for display.

---
 rtl/wordle_game_ctrl_if.sv | 34 +++
 rtl/wordle_game_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_wordle_game_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/wordle_game_ctrl_if.sv
// Switch-side controls and display-side status of the Wordle sequencer.
// Latency: none, signal bundle only.
// Backpressure: none; the master drives switches, the slave drives status.
interface wordle_game_ctrl_if #(
    parameter int NUM_DIGITS = 5,
    parameter int DIGIT_W    = 4
);
    logic [DIGIT_W-1:0]            digit_in;
    logic                          confirm;
    logic [1:0]                    mode;
    logic [3:0]                    state;
    logic [2:0]                    pos;
    logic [NUM_DIGITS*DIGIT_W-1:0] secret_flat;
    logic [NUM_DIGITS*DIGIT_W-1:0] guess_flat;
    logic [NUM_DIGITS-1:0]         green;
    logic [NUM_DIGITS-1:0]         yellow;
    logic [3:0]                    times_left;
    logic                          busy;
    logic                          win;
    logic                          lose;
    logic                          warning;

    modport master (
        output digit_in, confirm, mode,
        input  state, pos, secret_flat, guess_flat, green, yellow,
               times_left, busy, win, lose, warning
    );

    modport slave (
        input  digit_in, confirm, mode,
        output state, pos, secret_flat, guess_flat, green, yellow,
               times_left, busy, win, lose, warning
    );
endinterface

// File: rtl/wordle_game_ctrl.sv
// Wordle sequencer: setup, guess entry, per-position compare, win/lose.
// Latency: presses act on the edge they are seen; compare takes NUM_DIGITS cycles.
// Backpressure: none; presses arriving during COMPARE are dropped except abort.
module wordle_game_ctrl #(
    parameter int NUM_DIGITS = 5,
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGIT  = 9,
    parameter int MAX_TIMES  = 9
) (
    input logic               clk,
    input logic               rst_n,
    wordle_game_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SET_TIMES  = 4'd1,
        SET_DIGITS = 4'd2,
        READY      = 4'd3,
        GUESS      = 4'd4,
        COMPARE    = 4'd5,
        SHOW       = 4'd6,
        WIN        = 4'd7,
        LOSE       = 4'd8
    } state_t;

    localparam int                 FW       = NUM_DIGITS * DIGIT_W;
    localparam logic [2:0]         LAST_POS = 3'(NUM_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);
    localparam logic [DIGIT_W-1:0] MAX_T    = DIGIT_W'(MAX_TIMES);
    localparam logic [1:0]         M_SETUP  = 2'b10;
    localparam logic [1:0]         M_GUESS  = 2'b11;
    localparam logic [1:0]         M_ABORT  = 2'b01;

    state_t          state_q, state_d;
    logic [2:0]      pos_q, pos_d, cidx_q, cidx_d;
    logic [FW-1:0]   secret_q, secret_d, guess_q, guess_d;
    logic [NUM_DIGITS-1:0] green_q, green_d, yellow_q, yellow_d;
    logic [3:0]      times_q, times_d;
    logic            warning_q, warning_d, confirm_q;

    logic            press, abort, digit_ok, hit_green, hit_yellow;
    logic [DIGIT_W-1:0] s_arr [NUM_DIGITS];
    logic [DIGIT_W-1:0] g_arr [NUM_DIGITS];
    logic [DIGIT_W-1:0] g_cur, s_cur;

    assign press    = bus.confirm & ~confirm_q;
    assign abort    = press && (bus.mode == M_ABORT) && (state_q != IDLE);
    assign digit_ok = (bus.digit_in <= MAX_D);

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            s_arr[i] = secret_q[i*DIGIT_W +: DIGIT_W];
            g_arr[i] = guess_q[i*DIGIT_W +: DIGIT_W];
        end
    end

    // A secret digit only earns a yellow if it is not already consumed by its own green.
    always_comb begin
        g_cur      = g_arr[cidx_q];
        s_cur      = s_arr[cidx_q];
        hit_green  = (g_cur == s_cur);
        hit_yellow = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j != int'(cidx_q) && s_arr[j] == g_cur && g_arr[j] != s_arr[j])
                hit_yellow = 1'b1;
        end
        hit_yellow = hit_yellow & ~hit_green;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            cidx_q    <= '0;
            secret_q  <= '0;
            guess_q   <= '0;
            green_q   <= '0;
            yellow_q  <= '0;
            times_q   <= '0;
            warning_q <= 1'b0;
            confirm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            cidx_q    <= cidx_d;
            secret_q  <= secret_d;
            guess_q   <= guess_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            times_q   <= times_d;
            warning_q <= warning_d;
            confirm_q <= bus.confirm;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cidx_d    = cidx_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        green_d   = green_q;
        yellow_d  = yellow_q;
        times_d   = times_q;
        warning_d = warning_q;

        case (state_q)
            IDLE: begin
                if (bus.mode == M_SETUP) state_d = SET_TIMES;
            end
            SET_TIMES: begin
                if (press) begin
                    if (bus.digit_in != '0 && bus.digit_in <= MAX_T) begin
                        times_d   = 4'(bus.digit_in);
                        pos_d     = '0;
                        warning_d = 1'b0;
                        state_d   = SET_DIGITS;
                    end else begin
                        warning_d = 1'b1;
                    end
                end
            end
            SET_DIGITS: begin
                if (press) begin
                    if (digit_ok) begin
                        secret_d[pos_q*DIGIT_W +: DIGIT_W] = bus.digit_in;
                        warning_d = 1'b0;
                        if (pos_q == LAST_POS) begin
                            pos_d   = '0;
                            state_d = READY;
                        end else begin
                            pos_d = pos_q + 3'd1;
                        end
                    end else begin
                        warning_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.mode == M_GUESS) begin
                    guess_d = '0;
                    state_d = GUESS;
                end
            end
            GUESS: begin
                if (press) begin
                    if (digit_ok) begin
                        guess_d[pos_q*DIGIT_W +: DIGIT_W] = bus.digit_in;
                        warning_d = 1'b0;
                        if (pos_q == LAST_POS) begin
                            pos_d    = '0;
                            green_d  = '0;
                            yellow_d = '0;
                            cidx_d   = '0;
                            state_d  = COMPARE;
                        end else begin
                            pos_d = pos_q + 3'd1;
                        end
                    end else begin
                        warning_d = 1'b1;
                    end
                end
            end
            COMPARE: begin
                green_d[cidx_q]  = hit_green;
                yellow_d[cidx_q] = hit_yellow;
                if (cidx_q == LAST_POS) begin
                    cidx_d  = '0;
                    times_d = times_q - 4'd1;
                    if (&green_d)             state_d = WIN;
                    else if (times_q == 4'd1) state_d = LOSE;
                    else                      state_d = SHOW;
                end else begin
                    cidx_d = cidx_q + 3'd1;
                end
            end
            SHOW: begin
                if (press && bus.mode == M_GUESS) begin
                    guess_d = '0;
                    pos_d   = '0;
                    state_d = GUESS;
                end
            end
            WIN, LOSE: ;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            pos_d    = '0;
            cidx_d   = '0;
            secret_d = '0;
            guess_d  = '0;
            green_d  = '0;
            yellow_d = '0;
            times_d  = '0;
            warning_d = 1'b0;
        end

        if (state_d != state_q) warning_d = 1'b0;
    end

    assign bus.state       = state_q;
    assign bus.pos         = pos_q;
    assign bus.secret_flat = secret_q;
    assign bus.guess_flat  = guess_q;
    assign bus.green       = green_q;
    assign bus.yellow      = yellow_q;
    assign bus.times_left  = times_q;
    assign bus.busy        = (state_q == COMPARE);
    assign bus.win         = (state_q == WIN);
    assign bus.lose        = (state_q == LOSE);
    assign bus.warning     = warning_q;
endmodule

// File: tb/tb_wordle_game_ctrl.sv
// Directed bench for wordle_game_ctrl: setup, entry, compare, win/lose, abort and reset.
module tb_wordle_game_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    wordle_game_ctrl_if #(.NUM_DIGITS(5), .DIGIT_W(4)) bus ();

    wordle_game_ctrl #(
        .NUM_DIGITS(5), .DIGIT_W(4), .MAX_DIGIT(9), .MAX_TIMES(9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full press: confirm high for one cycle, low for one, ends on a negedge.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        bus.digit_in = d;
        bus.confirm  = 1'b1;
        @(negedge clk);
        bus.confirm  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_not_busy(input string tag);
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 20) begin
            checks++;
            errors++;
            $error("FAIL %s: busy still high after %0d cycles, required low", tag, cnt);
        end
    endtask

    task automatic setup_game(input logic [3:0] t, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
        @(negedge clk);
        bus.mode = 2'b10;
        @(negedge clk);
        press(t);
        press(s0); press(s1); press(s2); press(s3); press(s4);
        @(negedge clk);
        bus.mode = 2'b11;
        @(negedge clk);
    endtask

    initial begin
        bus.digit_in = '0;
        bus.confirm  = 1'b0;
        bus.mode     = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_times", bus.times_left, 0);
        chk("rst_secret", bus.secret_flat, 0);
        chk("rst_flags", {bus.busy, bus.win, bus.lose, bus.warning}, 0);
        rst_n = 1'b1;

        // Guess-limit entry with rejections at both ends of the range
        @(negedge clk);
        bus.mode = 2'b10;
        @(negedge clk);
        chk("idle_to_set_times", bus.state, 1);
        press(4'd15);
        chk("times15_warn", bus.warning, 1);
        chk("times15_state", bus.state, 1);
        press(4'd0);
        chk("times0_warn", bus.warning, 1);
        chk("times0_state", bus.state, 1);
        press(4'd4);
        chk("times4_val", bus.times_left, 4);
        chk("times4_state", bus.state, 2);
        chk("times4_warn", bus.warning, 0);

        // Secret entry with one rejected digit mid-way
        press(4'd2);
        press(4'd3);
        press(4'd10);
        chk("digit10_warn", bus.warning, 1);
        chk("digit10_pos", bus.pos, 2);
        press(4'd4);
        chk("digit_ok_warn", bus.warning, 0);
        press(4'd5);
        press(4'd6);
        chk("secret_val", bus.secret_flat, 32'h65432);
        chk("ready_state", bus.state, 3);

        // Miss: one wrong digit, busy exactly five cycles
        @(negedge clk);
        bus.mode = 2'b11;
        @(negedge clk);
        chk("guess_state", bus.state, 4);
        press(4'd2); press(4'd3); press(4'd4); press(4'd7);
        @(negedge clk);
        bus.digit_in = 4'd6;
        bus.confirm  = 1'b1;
        @(negedge clk);
        bus.confirm  = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, 5);
        chk("miss_green", bus.green, 5'b10111);
        chk("miss_yellow", bus.yellow, 0);
        chk("miss_times", bus.times_left, 3);
        chk("miss_state", bus.state, 6);
        chk("miss_guess", bus.guess_flat, 32'h67432);

        // Next round from SHOW: the consuming press stores no digit
        press(4'd8);
        chk("show_to_guess", bus.state, 4);
        chk("show_guess_clr", bus.guess_flat, 0);
        chk("show_pos", bus.pos, 0);
        press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6);
        wait_not_busy("win_wait");
        chk("win_flag", bus.win, 1);
        chk("win_state", bus.state, 7);
        chk("win_times", bus.times_left, 2);
        chk("win_green", bus.green, 5'b11111);
        repeat (3) @(negedge clk);
        chk("win_hold", bus.state, 7);

        // Abort from WIN
        bus.mode = 2'b01;
        press(4'd0);
        chk("abort_win_state", bus.state, 0);
        chk("abort_win_flag", bus.win, 0);
        chk("abort_win_secret", bus.secret_flat, 0);

        // Yellow rule on the last attempt, ending in LOSE
        setup_game(4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        chk("game2_secret", bus.secret_flat, 32'h54321);
        press(4'd2); press(4'd1); press(4'd3); press(4'd9); press(4'd9);
        wait_not_busy("lose_wait");
        chk("yel_green", bus.green, 5'b00100);
        chk("yel_yellow", bus.yellow, 5'b00011);
        chk("lose_flag", bus.lose, 1);
        chk("lose_state", bus.state, 8);
        chk("lose_times", bus.times_left, 0);

        // Abort from LOSE, then abort mid-guess
        bus.mode = 2'b01;
        press(4'd0);
        chk("abort_lose_state", bus.state, 0);
        setup_game(4'd3, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        press(4'd7);
        chk("mid_guess_pos", bus.pos, 1);
        bus.mode = 2'b01;
        press(4'd0);
        chk("abort_guess_state", bus.state, 0);
        chk("abort_guess_all", {bus.pos, bus.times_left, bus.warning}, 0);
        chk("abort_guess_data", bus.secret_flat | bus.guess_flat, 0);

        // Reset asserted during the second compare cycle
        setup_game(4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        @(negedge clk);
        bus.digit_in = 4'd0;
        bus.confirm  = 1'b1;
        @(negedge clk);
        bus.confirm  = 1'b0;
        chk("cmp_busy", bus.busy, 1);
        @(negedge clk);
        chk("cmp_green_partial", bus.green, 5'b00001);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cmp_state", bus.state, 0);
        chk("rst_cmp_flags", {bus.busy, bus.green, bus.yellow, bus.times_left}, 0);
        chk("rst_cmp_data", bus.secret_flat | bus.guess_flat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
